// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM encodings and frame limits.
package loader_pkg;

  localparam int MAX_LEN = 16;
  // One extra bit so a count of MAX_LEN is representable without wrapping to zero.
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  function automatic logic len_ok(input logic [7:0] b);
    return (b != 8'd0) && (b <= 8'(MAX_LEN));
  endfunction

endpackage

// File: rtl/program_loader.sv
// Accepts a LEN/payload/CSUM frame, writes the payload into instruction memory,
// and hands memory to the controller (op) when the checksum matches.
//
// state | meaning
// IDLE  | waiting for start, no bytes accepted
// LEN   | expecting the length byte
// LOAD  | streaming payload bytes into memory
// CHECK | expecting the checksum byte
// RUN   | frame good, controller owns memory
// ERR   | frame rejected, error held
module program_loader
  import loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] user_address,
  output logic [DATA_W-1:0] data_in,
  output logic              write_memory,
  output logic              op,
  output logic              busy,
  output logic              error
);

  state_t             state;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sum;
  logic               xfer;
  logic [CNT_W-1:0]   cnt_nxt;

  assign in_ready = (state == S_LEN) || (state == S_LOAD) || (state == S_CHECK);
  assign busy     = in_ready;
  // start takes priority over any byte presented in the same cycle.
  assign xfer     = in_valid && in_ready && !start;
  assign cnt_nxt  = cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      len          <= '0;
      cnt          <= '0;
      sum          <= '0;
      user_address <= '0;
      data_in      <= '0;
      write_memory <= 1'b0;
      op           <= 1'b0;
      error        <= 1'b0;
    end else begin
      write_memory <= 1'b0;
      if (start) begin
        state <= S_LEN;
        cnt   <= '0;
        sum   <= '0;
        op    <= 1'b0;
        error <= 1'b0;
      end else begin
        case (state)
          S_LEN: begin
            if (xfer) begin
              if (len_ok(8'(in_data))) begin
                len   <= CNT_W'(in_data);
                cnt   <= '0;
                sum   <= '0;
                state <= S_LOAD;
              end else begin
                error <= 1'b1;
                state <= S_ERR;
              end
            end
          end
          S_LOAD: begin
            if (xfer) begin
              data_in      <= in_data;
              user_address <= cnt[ADDR_W-1:0];
              write_memory <= 1'b1;
              sum          <= sum + in_data;
              cnt          <= cnt_nxt;
              if (cnt_nxt == len) state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (xfer) begin
              if (in_data == sum) begin
                op    <= 1'b1;
                state <= S_RUN;
              end else begin
                error <= 1'b1;
                state <= S_ERR;
              end
            end
          end
          S_RUN:   state <= S_RUN;
          S_ERR:   state <= S_ERR;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame vectors with hand-computed writes, op and error.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] user_address;
  logic [7:0] data_in;
  logic       write_memory;
  logic       op;
  logic       busy;
  logic       error;

  int n_chk  = 0;
  int n_pass = 0;
  int wcount = 0;
  int overlap = 0;

  program_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .user_address(user_address), .data_in(data_in),
    .write_memory(write_memory), .op(op), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_memory) wcount = wcount + 1;
    if (write_memory && op) overlap = overlap + 1;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_payload(input string tag, input logic [7:0] b, input logic [3:0] addr);
    send(b);
    chk({tag, "_we"}, 8'(write_memory), 8'd1);
    chk({tag, "_addr"}, 8'(user_address), 8'(addr));
    chk({tag, "_data"}, data_in, b);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    chk("rst_ready", 8'(in_ready), 8'd0);
    chk("rst_we", 8'(write_memory), 8'd0);
    chk("rst_addr", 8'(user_address), 8'd0);
    chk("rst_data", data_in, 8'd0);
    chk("rst_op", 8'(op), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_err", 8'(error), 8'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // good frame, back-to-back
    pulse_start();
    chk("g_busy", 8'(busy), 8'd1);
    chk("g_ready", 8'(in_ready), 8'd1);
    wcount = 0; overlap = 0;
    send(8'd3);
    chk("g_len_we", 8'(write_memory), 8'd0);
    send_payload("g0", 8'h11, 4'd0);
    send_payload("g1", 8'h22, 4'd1);
    send_payload("g2", 8'h33, 4'd2);
    send(8'h66);
    chk("g_op", 8'(op), 8'd1);
    chk("g_err", 8'(error), 8'd0);
    chk("g_we_off", 8'(write_memory), 8'd0);
    chk("g_busy_off", 8'(busy), 8'd0);
    send(8'h55);
    chk("g_run_ready", 8'(in_ready), 8'd0);
    chk("g_run_op", 8'(op), 8'd1);
    tick();
    chk("g_wcount", 8'(wcount), 8'd3);

    // bad checksum
    pulse_start();
    chk("b_op_clr", 8'(op), 8'd0);
    wcount = 0;
    send(8'd3);
    send_payload("b0", 8'h11, 4'd0);
    send_payload("b1", 8'h22, 4'd1);
    send_payload("b2", 8'h33, 4'd2);
    send(8'h65);
    chk("b_err", 8'(error), 8'd1);
    chk("b_op", 8'(op), 8'd0);
    chk("b_ready", 8'(in_ready), 8'd0);
    tick();
    chk("b_wcount", 8'(wcount), 8'd3);

    // illegal lengths
    pulse_start();
    chk("l_err_clr", 8'(error), 8'd0);
    wcount = 0;
    send(8'd0);
    chk("l0_err", 8'(error), 8'd1);
    send(8'd5);
    pulse_start();
    chk("l17_err_clr", 8'(error), 8'd0);
    send(8'd17);
    chk("l17_err", 8'(error), 8'd1);
    tick();
    chk("l_wcount", 8'(wcount), 8'd0);

    // full depth, throttled
    pulse_start();
    wcount = 0; overlap = 0;
    send(8'd16);
    for (int i = 0; i < 16; i++) begin
      send_payload("f", 8'hF0 + 8'(i), 4'(i));
      tick();
      chk("f_gap_we", 8'(write_memory), 8'd0);
    end
    chk("f_last_addr", 8'(user_address), 8'd15);
    chk("f_busy", 8'(busy), 8'd1);
    send(8'h78);
    chk("f_op", 8'(op), 8'd1);
    chk("f_err", 8'(error), 8'd0);
    tick();
    chk("f_wcount", 8'(wcount), 8'd16);
    chk("f_overlap", 8'(overlap), 8'd0);

    // abort mid-payload, start coinciding with a byte
    pulse_start();
    wcount = 0;
    send(8'd5);
    send_payload("a0", 8'h01, 4'd0);
    send_payload("a1", 8'h02, 4'd1);
    in_valid = 1'b1; in_data = 8'h03;
    pulse_start();
    in_valid = 1'b0;
    chk("a_drop_we", 8'(write_memory), 8'd0);
    chk("a_busy", 8'(busy), 8'd1);
    chk("a_op", 8'(op), 8'd0);
    chk("a_err", 8'(error), 8'd0);
    send(8'd1);
    send_payload("a_new", 8'hAA, 4'd0);
    send(8'hAA);
    chk("a_new_op", 8'(op), 8'd1);
    tick();
    chk("a_wcount", 8'(wcount), 8'd3);

    // async reset mid-load
    pulse_start();
    send(8'd3);
    send_payload("r0", 8'h11, 4'd0);
    in_valid = 1'b1; in_data = 8'h22;
    #2 reset = 1'b1;
    #1;
    chk("r_we", 8'(write_memory), 8'd0);
    chk("r_addr", 8'(user_address), 8'd0);
    chk("r_data", data_in, 8'd0);
    chk("r_busy", 8'(busy), 8'd0);
    chk("r_ready", 8'(in_ready), 8'd0);
    chk("r_op", 8'(op), 8'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    wcount = 0;
    for (int i = 0; i < 4; i++) send(8'd2);
    chk("r_idle_ready", 8'(in_ready), 8'd0);
    chk("r_idle_busy", 8'(busy), 8'd0);
    chk("r_idle_wcount", 8'(wcount), 8'd0);
    pulse_start();
    chk("r_restart_busy", 8'(busy), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that sits directly upstream of the controller/memory integration. It accepts a framed program over a valid/ready byte interface, writes each payload byte into the 16×8 instruction memory through that memory's user write path (address, data, write strobe), and verifies a checksum. On a good frame it raises `op` to hand the memory address mux to the control unit and start execution. On a bad frame it holds `op` low and flags an error.

## Interface
Parameters:
- `DATA_W`, 8: byte and memory word width.
- `ADDR_W`, 4: memory address width; depth is 2^ADDR_W = 16.

Ports:
- `clk`, in, 1: single system clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state and outputs immediately.
- `start`, in, 1: single-cycle pulse that begins or restarts a load.
- `in_valid`, in, 1: `in_data` holds a valid byte.
- `in_data`, in, DATA_W: incoming frame byte.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `user_address`, out, ADDR_W: memory write address, registered.
- `data_in`, out, DATA_W: memory write data, registered.
- `write_memory`, out, 1: memory write strobe, registered, one cycle per payload byte.
- `op`, out, 1: run enable to the controller and address mux; 1 means the control unit owns the memory.
- `busy`, out, 1: a load is in progress.
- `error`, out, 1: last frame rejected; sticky until the next `start` or `reset`.

## Operation
- Frame format: `LEN`, then `LEN` payload bytes, then `CSUM`.
  - `LEN` must be in 1..16.
  - `CSUM` is the 8-bit modulo-256 sum of the payload bytes.
- A byte transfers on a cycle where `in_valid` and `in_ready` are both 1.
- FSM states: IDLE, LEN, LOAD, CHECK, RUN, ERR.
  - IDLE: `in_ready`=0. `start` moves to LEN.
  - LEN: `in_ready`=1.
    - Accepted byte 0 or >16 moves to ERR.
    - Otherwise store `len`, clear `cnt` and `sum`, move to LOAD.
  - LOAD: `in_ready`=1. Each accepted byte is registered to `data_in`, with `user_address`=`cnt[3:0]` and `write_memory`=1 on the next cycle. Then `sum` += byte (wraps mod 256) and `cnt`++. Moves to CHECK once `cnt` reaches `len`.
  - CHECK: `in_ready`=1.
    - Accepted byte == `sum` moves to RUN.
    - Otherwise moves to ERR.
  - RUN: `op`=1, `in_ready`=0. Stays in RUN indefinitely.
  - ERR: `error`=1, `op`=0, `in_ready`=0. Stays in ERR.
- `start` in any state aborts the current frame. Next cycle: state=LEN, `op`=0, `error`=0, `cnt`=`sum`=0. Memory contents already written are not erased.
- `start` in the same cycle as a byte handshake: the byte is dropped and `start` wins.
- `busy`=1 in LEN, LOAD and CHECK.
- Bytes with `in_ready`=0 are ignored, not buffered.

## Timing
- Reset values: state=IDLE; `in_ready`=0, `write_memory`=0, `user_address`=0, `data_in`=0, `op`=0, `busy`=0, `error`=0.
- `write_memory` is high exactly one cycle, the cycle after a LOAD handshake. `user_address`/`data_in` are valid in that cycle.
- Back-to-back payload bytes are accepted every cycle: throughput 1 byte/cycle, write latency 1 cycle.
- `op` rises the cycle after the CHECK handshake. It is never high while `write_memory` is high, because the last write precedes CHECK by at least one cycle.
- `in_ready` is a combinational decode of state. `write_memory`, `user_address`, `data_in`, `op` and `error` are registered.
- Boundary condition, `LEN`=16: `cnt` is 5 bits. Addresses 0..15 are written, with no wrap onto address 0.
- Reset mid-LOAD forces all outputs to their reset values immediately. A pending write is lost.

## Structure
- Shared package `loader_pkg`: state enum (IDLE, LEN, LOAD, CHECK, RUN, ERR) and `MAX_LEN` = 16.
- Single flat module. Datapath is three registers (`len`, `cnt`, `sum`) plus the output registers; no sub-module is needed.
- At the top level, `user_address`/`data_in`/`write_memory`/`op` connect directly to the same-named integration ports.

## Test plan
- Good frame: `LEN`=3, payload 0x11 0x22 0x33, `CSUM`=0x66, streamed back-to-back → writes at addresses 0,1,2 on consecutive cycles with those values; `op`=1 one cycle after `CSUM`; `error`=0.
- Bad checksum: same frame with `CSUM`=0x65 → three writes occur, then `error`=1, `op`=0, state ERR.
- Illegal length: `LEN`=0, then separately `LEN`=17 → no `write_memory` pulse, `error`=1.
- Full depth with throttled `in_valid`: `LEN`=16, payload 0xF0..0xFF, `CSUM`=0x78, `in_valid` toggled every other cycle → 16 writes to addresses 0..15 with no wrap; `op`=1 after `CSUM`.
- Abort: `start` pulsed after 2 of 5 payload bytes, then a good `LEN`=1, 0xAA, `CSUM`=0xAA frame → the new frame writes 0xAA to address 0; `op`=1.
- Async reset during LOAD → outputs zero without waiting for a clock edge; IDLE ignores `in_valid` until the next `start`.
